sdrd_word_collector: RTL and testbench

//  Downstream consumer of the serial-read sequencer's SDRD bit. One bit is sampled
//  per qualified bus read strobe, and WORD_W bits are assembled into a word.

---
 rtl/sdrd_word_collector.sv | 116 +++++++++++
 tb/tb_sdrd_word_collector.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/sdrd_word_collector.sv
// Assembles SDRD bits sampled on qualified read strobes into WORD_W-bit words and
// hands them to the host through a one-entry valid/ready buffer, flagging bad reads, gaps and overruns.
module sdrd_word_collector #(
   parameter int WORD_W    = 8,
   parameter int LSB_FIRST = 1,
   parameter int TIMEOUT   = 255,
   parameter int TMR_W     = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              acc_stb,
   input  logic              sdrd,
   input  logic              sdrd_z,
   input  logic              flush,
   output logic [WORD_W-1:0] out_word,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [4:0]        bit_cnt,
   output logic              bit_err,
   output logic              tmo,
   output logic              ovf,
   input  logic              ovf_clr
);

   localparam int TMO_M1 = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

   logic [WORD_W-1:0] sr;
   logic [TMR_W-1:0]  timer;

   logic [WORD_W-1:0] sr_shift;
   logic              accept;
   logic              bad;
   logic              last;
   logic              part;
   logic              expire;
   logic              pop;
   logic              load;
   logic              drop;

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      sr_shift = sr;
      accept   = 1'b0;
      bad      = 1'b0;
      last     = 1'b0;
      part     = 1'b0;
      expire   = 1'b0;
      pop      = 1'b0;
      load     = 1'b0;
      drop     = 1'b0;

      // flush swallows a coincident strobe entirely, good or bad
      accept = acc_stb & ~sdrd_z & ~flush;
      bad    = acc_stb &  sdrd_z & ~flush;
      part   = (bit_cnt != 5'd0);
      last   = accept && (bit_cnt == 5'(WORD_W - 1));

      if (LSB_FIRST != 0) sr_shift = {sdrd, sr[WORD_W-1:1]};
      else                sr_shift = {sr[WORD_W-2:0], sdrd};

      // expiry fires on the TIMEOUT-th idle cycle; a bit accepted in that cycle wins
      expire = (TIMEOUT != 0) && part && !accept && !bad && !flush
               && (timer == TMR_W'(TMO_M1));

      pop  = out_valid & out_ready;
      load = last & (~out_valid | pop);
      drop = last & out_valid & ~pop;
   end

   // NOTE: all state is updated with non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         sr        <= '0;
         bit_cnt   <= '0;
         timer     <= '0;
         out_word  <= '0;
         out_valid <= 1'b0;
         bit_err   <= 1'b0;
         tmo       <= 1'b0;
         ovf       <= 1'b0;
      end else begin
         bit_err <= bad;
         tmo     <= expire;

         if (flush || bad || expire) begin
            sr      <= '0;
            bit_cnt <= '0;
            timer   <= '0;
         end else if (accept) begin
            timer <= '0;
            if (last) begin
               sr      <= '0;
               bit_cnt <= '0;
            end else begin
               sr      <= sr_shift;
               bit_cnt <= bit_cnt + 5'd1;
            end
         end else if (part) begin
            timer <= timer + TMR_W'(1);
         end else begin
            timer <= '0;
         end

         if (load) begin
            out_word  <= sr_shift;
            out_valid <= 1'b1;
         end else if (pop) begin
            out_valid <= 1'b0;
         end

         if (drop)         ovf <= 1'b1;
         else if (ovf_clr) ovf <= 1'b0;
      end
   end

endmodule

// File: tb/tb_sdrd_word_collector.sv
// Directed bench: an LSB-first and an MSB-first collector share stimulus; table vectors
// cover basic assembly, bit errors and flush, hand sequences cover overrun, timeout and reset.
module tb_sdrd_word_collector;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       acc_stb = 1'b0;
   logic       sdrd = 1'b0;
   logic       sdrd_z = 1'b0;
   logic       flush = 1'b0;
   logic       out_ready = 1'b0;
   logic       ovf_clr = 1'b0;

   logic [7:0] word_l, word_m;
   logic       valid_l, valid_m;
   logic [4:0] cnt_l, cnt_m;
   logic       err_l, err_m, tmo_l, tmo_m, ovf_l, ovf_m;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   sdrd_word_collector #(.WORD_W(8), .LSB_FIRST(1), .TIMEOUT(4), .TMR_W(8)) dut_lsb (
      .clk(clk), .rst(rst), .acc_stb(acc_stb), .sdrd(sdrd), .sdrd_z(sdrd_z), .flush(flush),
      .out_word(word_l), .out_valid(valid_l), .out_ready(out_ready), .bit_cnt(cnt_l),
      .bit_err(err_l), .tmo(tmo_l), .ovf(ovf_l), .ovf_clr(ovf_clr)
   );

   sdrd_word_collector #(.WORD_W(8), .LSB_FIRST(0), .TIMEOUT(4), .TMR_W(8)) dut_msb (
      .clk(clk), .rst(rst), .acc_stb(acc_stb), .sdrd(sdrd), .sdrd_z(sdrd_z), .flush(flush),
      .out_word(word_m), .out_valid(valid_m), .out_ready(out_ready), .bit_cnt(cnt_m),
      .bit_err(err_m), .tmo(tmo_m), .ovf(ovf_m), .ovf_clr(ovf_clr)
   );

   typedef struct {
      logic       acc, bv, z, fl, rdy, clr;
      logic       valid;
      logic [7:0] wl, wm;
      logic [4:0] cnt;
      logic       err, tmo, ovf;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic acc, bv, z, fl, rdy, clr, valid,
                               input logic [7:0] wl, wm, input logic [4:0] cnt,
                               input logic err, tmo, ovf);
      vec_t v;
      v.acc = acc; v.bv = bv; v.z = z; v.fl = fl; v.rdy = rdy; v.clr = clr;
      v.valid = valid; v.wl = wl; v.wm = wm; v.cnt = cnt;
      v.err = err; v.tmo = tmo; v.ovf = ovf;
      return v;
   endfunction

   // word as seen by an MSB-first collector when bits go out in LSB-first order
   function automatic logic [7:0] rev(input logic [7:0] x);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[i] = x[7-i];
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic expect_all(input string tag, input logic valid, input logic [7:0] wl, wm,
                             input logic [4:0] cnt, input logic err, t, o);
      check({tag, " lsb.valid"}, 32'(valid_l), 32'(valid));
      check({tag, " msb.valid"}, 32'(valid_m), 32'(valid));
      if (valid) begin
         check({tag, " lsb.word"}, 32'(word_l), 32'(wl));
         check({tag, " msb.word"}, 32'(word_m), 32'(wm));
      end
      check({tag, " lsb.cnt"}, 32'(cnt_l), 32'(cnt));
      check({tag, " msb.cnt"}, 32'(cnt_m), 32'(cnt));
      check({tag, " bit_err"}, 32'({err_l, err_m}), 32'({err, err}));
      check({tag, " tmo"},     32'({tmo_l, tmo_m}), 32'({t, t}));
      check({tag, " ovf"},     32'({ovf_l, ovf_m}), 32'({o, o}));
   endtask

   task automatic drive(input logic a, b, z, f, r, c);
      @(negedge clk);
      acc_stb = a; sdrd = b; sdrd_z = z; flush = f; out_ready = r; ovf_clr = c;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   // seq[i] is the i-th bit sent; ready/clear apply on the final strobe only
   task automatic send_word(input logic [7:0] seq, input logic rdy_last, input logic clr_last);
      for (int i = 0; i < 8; i++)
         drive(1'b1, seq[i], 1'b0, 1'b0, (i == 7) ? rdy_last : 1'b0, (i == 7) ? clr_last : 1'b0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      acc_stb = 1'b0; sdrd = 1'b0; sdrd_z = 1'b0; flush = 1'b0; out_ready = 1'b0; ovf_clr = 1'b0;
      @(posedge clk);
      #1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      logic [7:0] a5 = 8'hA5;
      logic [7:0] c0 = 8'hC0;

      // bits 1,0,1,0,0,1,0,1 -> A5 on both orderings
      for (int i = 0; i < 8; i++)
         vecs.push_back(mk(1, a5[7-i], 0, 0, 0, 0, (i == 7), 8'hA5, 8'hA5, 5'((i + 1) % 8), 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 8'h00, 8'h00, 5'd0, 0, 0, 0));
      // bits 1,1,0,0,0,0,0,0 -> C0 MSB-first, 03 LSB-first
      for (int i = 0; i < 8; i++)
         vecs.push_back(mk(1, c0[7-i], 0, 0, 0, 0, (i == 7), 8'h03, 8'hC0, 5'((i + 1) % 8), 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 8'h00, 8'h00, 5'd0, 0, 0, 0));
      // five bits then an undriven read
      for (int i = 0; i < 5; i++)
         vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 5'(i + 1), 0, 0, 0));
      vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0, 8'h00, 8'h00, 5'd0, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 5'd0, 0, 0, 0));
      // flush with coincident strobe, good and undriven
      vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 5'd1, 0, 0, 0));
      vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 5'd2, 0, 0, 0));
      vecs.push_back(mk(1, 1, 0, 1, 0, 0, 0, 8'h00, 8'h00, 5'd0, 0, 0, 0));
      vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 5'd1, 0, 0, 0));
      vecs.push_back(mk(1, 0, 1, 1, 0, 0, 0, 8'h00, 8'h00, 5'd0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 5'd0, 0, 0, 0));

      repeat (2) @(posedge clk);
      #1;
      expect_all("reset", 1'b0, 8'h00, 8'h00, 5'd0, 1'b0, 1'b0, 1'b0);
      check("reset lsb.word", 32'(word_l), 32'h0);
      check("reset msb.word", 32'(word_m), 32'h0);
      @(negedge clk);
      rst = 1'b0;

      foreach (vecs[i]) begin
         drive(vecs[i].acc, vecs[i].bv, vecs[i].z, vecs[i].fl, vecs[i].rdy, vecs[i].clr);
         expect_all($sformatf("vec%0d", i), vecs[i].valid, vecs[i].wl, vecs[i].wm,
                    vecs[i].cnt, vecs[i].err, vecs[i].tmo, vecs[i].ovf);
      end

      // overrun: buffer held, second word dropped, clear, then set beats clear
      do_reset();
      send_word(8'h0F, 1'b0, 1'b0);
      expect_all("fill", 1'b1, 8'h0F, rev(8'h0F), 5'd0, 1'b0, 1'b0, 1'b0);
      send_word(8'h3C, 1'b0, 1'b0);
      expect_all("overrun", 1'b1, 8'h0F, rev(8'h0F), 5'd0, 1'b0, 1'b0, 1'b1);
      idle();
      expect_all("ovf_hold", 1'b1, 8'h0F, rev(8'h0F), 5'd0, 1'b0, 1'b0, 1'b1);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      expect_all("ovf_clr", 1'b1, 8'h0F, rev(8'h0F), 5'd0, 1'b0, 1'b0, 1'b0);
      send_word(8'h55, 1'b0, 1'b1);
      expect_all("ovf_set_wins", 1'b1, 8'h0F, rev(8'h0F), 5'd0, 1'b0, 1'b0, 1'b1);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

      // word completes on the same edge the old one pops
      send_word(8'h96, 1'b1, 1'b0);
      expect_all("pop_and_load", 1'b1, 8'h96, rev(8'h96), 5'd0, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      expect_all("pop", 1'b0, 8'h00, 8'h00, 5'd0, 1'b0, 1'b0, 1'b0);

      // reset with full buffer and a partial word
      send_word(8'h11, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      expect_all("pre_rst", 1'b1, 8'h11, rev(8'h11), 5'd3, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      acc_stb = 1'b0;
      @(posedge clk);
      #1;
      expect_all("mid_rst", 1'b0, 8'h00, 8'h00, 5'd0, 1'b0, 1'b0, 1'b0);
      check("mid_rst lsb.word", 32'(word_l), 32'h0);
      check("mid_rst msb.word", 32'(word_m), 32'h0);
      @(negedge clk);
      rst = 1'b0;

      // gap timeout after three bits
      for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         idle();
         expect_all($sformatf("gap%0d", i + 1), 1'b0, 8'h00, 8'h00, 5'd3, 1'b0, 1'b0, 1'b0);
      end
      idle();
      expect_all("timeout", 1'b0, 8'h00, 8'h00, 5'd0, 1'b0, 1'b1, 1'b0);
      idle();
      expect_all("tmo_pulse_end", 1'b0, 8'h00, 8'h00, 5'd0, 1'b0, 1'b0, 1'b0);

      // strobe on the expiry cycle wins and reloads the timer
      for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (3) idle();
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      expect_all("expiry_strobe", 1'b0, 8'h00, 8'h00, 5'd4, 1'b0, 1'b0, 1'b0);
      repeat (3) idle();
      expect_all("reloaded", 1'b0, 8'h00, 8'h00, 5'd4, 1'b0, 1'b0, 1'b0);
      idle();
      expect_all("timeout2", 1'b0, 8'h00, 8'h00, 5'd0, 1'b0, 1'b1, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
